// File: rtl/png_idat_zlib_if.sv
// png_idat_zlib_if: control, pixel input and packed word output of the IDAT zlib generator
interface png_idat_zlib_if;
  logic [31:0] w_i;
  logic [31:0] h_i;
  logic        start_i;
  logic        pix_val_i;
  logic [31:0] pix_dat_i;
  logic        pix_rdy_o;
  logic        val_o;
  logic [31:0] dat_o;
  logic        lst_o;
  logic [2:0]  lst_nb_o;
  logic [31:0] len_o;
  logic        done_o;
  logic        busy_o;
  modport slave (
    input  w_i, h_i, start_i, pix_val_i, pix_dat_i,
    output pix_rdy_o, val_o, dat_o, lst_o, lst_nb_o, len_o, done_o, busy_o
  );
  modport master (
    output w_i, h_i, start_i, pix_val_i, pix_dat_i,
    input  pix_rdy_o, val_o, dat_o, lst_o, lst_nb_o, len_o, done_o, busy_o
  );
endinterface

// File: rtl/png_idat_zlib.sv
// png_idat_zlib: RGBA8 raster rows to a zlib stored-block IDAT payload packed in big-endian words
module png_idat_zlib (
  input logic            clk,
  input logic            rstn,
  png_idat_zlib_if.slave bus
);
  localparam logic [31:0] W_MAX = 32'd16383;
  typedef enum logic [2:0] {IDLE, ZHDR, BHD0, BHD1, PIX, ADLR, FLSH} st_t;
  st_t         st_q, st_d;
  logic [13:0] w_q, w_d, col_q, col_d;
  logic [31:0] h_q, h_d, row_q, row_d, len_q, len_d;
  logic [15:0] s1_q, s1_d, s2_q, s2_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        val_q, val_d, lst_q, lst_d, done_q, done_d, busy_q, busy_d, rdy_q, rdy_d;
  logic [31:0] dat_q, dat_d;
  logic [2:0]  nb_q, nb_d;
  logic [31:0] ins_b;
  logic [2:0]  ins_n, tot;
  logic [55:0] mrg;
  logic [15:0] blen;
  logic [7:0]  b0, b1, b2, b3;
  logic        last_col, last_row, start_ok;
  // Reduces any sum below 6*65521 into [0, 65520] with chained conditional subtracts.
  function automatic logic [15:0] mod_a(input logic [19:0] x);
    logic [19:0] r;
    r = x;
    for (int i = 0; i < 5; i++) r = (r >= 20'd65521) ? r - 20'd65521 : r;
    return 16'(r);
  endfunction
  assign {b0, b1, b2, b3} = bus.pix_dat_i;
  assign blen = {w_q, 2'b00} + 16'd1;
  assign last_col = col_q == w_q - 14'd1;
  assign last_row = row_q == h_q - 32'd1;
  assign start_ok = bus.start_i && bus.w_i != 32'd0 && bus.w_i <= W_MAX && bus.h_i != 32'd0;
  assign tot = {1'b0, cnt_q} + ins_n;
  assign mrg = {acc_q, 32'h0} | ({ins_b, 24'h0} >> {cnt_q, 3'b000});
  // Frame sequencing, byte insertion, Adler-32 update and word packing.
  always_comb begin
    st_d = st_q;
    w_d = w_q;
    h_d = h_q;
    col_d = col_q;
    row_d = row_q;
    len_d = len_q;
    s1_d = s1_q;
    s2_d = s2_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ins_b = '0;
    ins_n = '0;
    val_d = 1'b0;
    lst_d = 1'b0;
    nb_d = '0;
    dat_d = '0;
    done_d = 1'b0;
    case (st_q)
      IDLE: if (start_ok) begin
        st_d = ZHDR;
        w_d = bus.w_i[13:0];
        h_d = bus.h_i;
        len_d = 32'd6 + bus.h_i * (32'd6 + {bus.w_i[29:0], 2'b00});
        col_d = '0;
        row_d = '0;
        s1_d = 16'd1;
        s2_d = 16'd0;
      end
      ZHDR: begin
        ins_b = 32'h7801_0000;
        ins_n = 3'd2;
        st_d = BHD0;
      end
      BHD0: begin
        ins_b = {last_row ? 8'h01 : 8'h00, blen[7:0], blen[15:8], ~blen[7:0]};
        ins_n = 3'd4;
        st_d = BHD1;
      end
      BHD1: begin
        ins_b = {~blen[15:8], 24'h0};
        ins_n = 3'd2;
        s2_d = mod_a(20'(s2_q) + 20'(s1_q));
        st_d = PIX;
      end
      PIX: if (bus.pix_val_i) begin
        ins_b = bus.pix_dat_i;
        ins_n = 3'd4;
        s1_d = mod_a(20'(s1_q) + 20'(b0) + 20'(b1) + 20'(b2) + 20'(b3));
        s2_d = mod_a(20'(s2_q) + 20'({s1_q, 2'b00}) + 20'({b0, 2'b00}) + 20'({b1, 1'b0})
                     + 20'(b1) + 20'({b2, 1'b0}) + 20'(b3));
        col_d = last_col ? 14'd0 : col_q + 14'd1;
        row_d = last_col && !last_row ? row_q + 32'd1 : row_q;
        st_d = !last_col ? PIX : last_row ? ADLR : BHD0;
      end
      ADLR: begin
        ins_b = {s2_q, s1_q};
        ins_n = 3'd4;
        st_d = FLSH;
      end
      FLSH: if (cnt_q != 2'd0) begin
        val_d = 1'b1;
        lst_d = 1'b1;
        nb_d = {1'b0, cnt_q};
        dat_d = {acc_q, 8'h00};
        acc_d = '0;
        cnt_d = '0;
      end else begin
        done_d = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (ins_n != 3'd0) begin
      val_d = tot[2];
      dat_d = tot[2] ? mrg[55:24] : 32'h0;
      acc_d = tot[2] ? mrg[23:0] : mrg[55:32];
      cnt_d = tot[1:0];
      lst_d = st_q == ADLR && tot == 3'd4;
      nb_d = lst_d ? 3'd4 : 3'd0;
    end
    busy_d = st_d != IDLE || done_d;
    rdy_d = st_d == PIX;
  end
  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q <= IDLE;
      w_q <= '0;
      h_q <= '0;
      col_q <= '0;
      row_q <= '0;
      len_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      val_q <= 1'b0;
      lst_q <= 1'b0;
      nb_q <= '0;
      dat_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      w_q <= w_d;
      h_q <= h_d;
      col_q <= col_d;
      row_q <= row_d;
      len_q <= len_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      lst_q <= lst_d;
      nb_q <= nb_d;
      dat_q <= dat_d;
      done_q <= done_d;
      busy_q <= busy_d;
      rdy_q <= rdy_d;
    end
  end
  assign bus.pix_rdy_o = rdy_q;
  assign bus.val_o = val_q;
  assign bus.dat_o = dat_q;
  assign bus.lst_o = lst_q;
  assign bus.lst_nb_o = nb_q;
  assign bus.len_o = len_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_png_idat_zlib.sv
// tb_png_idat_zlib: directed frames against a byte-level zlib stored-block and Adler-32 model
module tb_png_idat_zlib;
  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [2:0]  n;
  } ew_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  int lst_total = 0;
  int done_total = 0;
  int low_run = 0;
  logic armed = 1'b0;
  logic rdy_prev = 1'b0;
  logic lst_prev = 1'b0;
  ew_t exp_q[$];
  logic [31:0] px[$];
  png_idat_zlib_if bus();
  png_idat_zlib dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Reference stream: plain byte-serial Adler-32 and stored-block framing.
  task automatic model(input int w, input int h);
    logic [7:0] b[$];
    int unsigned s1, s2;
    logic [15:0] ln;
    logic [31:0] pw;
    logic [7:0] bb;
    ew_t e;
    int k;
    s1 = 1;
    s2 = 0;
    k = 0;
    ln = 16'(1 + 4 * w);
    b.push_back(8'h78);
    b.push_back(8'h01);
    for (int r = 0; r < h; r++) begin
      b.push_back(r == h - 1 ? 8'h01 : 8'h00);
      b.push_back(ln[7:0]);
      b.push_back(ln[15:8]);
      b.push_back(~ln[7:0]);
      b.push_back(~ln[15:8]);
      b.push_back(8'h00);
      s2 = (s2 + s1) % 65521;
      for (int c = 0; c < w; c++) begin
        pw = px[k];
        k++;
        for (int j = 3; j >= 0; j--) begin
          bb = pw[8*j +: 8];
          b.push_back(bb);
          s1 = (s1 + bb) % 65521;
          s2 = (s2 + s1) % 65521;
        end
      end
    end
    b.push_back(s2[15:8]);
    b.push_back(s2[7:0]);
    b.push_back(s1[15:8]);
    b.push_back(s1[7:0]);
    for (int i = 0; i < b.size(); i += 4) begin
      e.d = '0;
      for (int j = 0; j < 4; j++) if (i + j < b.size()) e.d[31-8*j -: 8] = b[i+j];
      e.l = i + 4 >= b.size();
      e.n = e.l ? 3'(b.size() - i) : 3'd0;
      exp_q.push_back(e);
    end
  endtask
  task automatic start(input int w, input int h);
    @(negedge clk);
    bus.w_i = w;
    bus.h_i = h;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask
  task automatic drive_px(input int gaps, input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.pix_val_i = 1'b0;
      end
      @(negedge clk);
      bus.pix_val_i = 1'b1;
      bus.pix_dat_i = px[i];
      n = 0;
      while (bus.pix_rdy_o !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("pix_rdy", bus.pix_rdy_o, 1'b1);
    end
    @(negedge clk);
    bus.pix_val_i = 1'b0;
  endtask
  task automatic frame(input int w, input int h, input int gaps, input int bsy, input int mdl);
    int n, d0, l0, lim;
    if (mdl != 0) model(w, h);
    d0 = done_total;
    l0 = lst_total;
    start(w, h);
    chk("busy_after_start", bus.busy_o, 1'b1);
    chk("len", bus.len_o, 32'(6 + h * (6 + 4 * w)));
    if (bsy != 0) begin
      start(w + 4, h + 4);
      chk("len_hold_busy_start", bus.len_o, 32'(6 + h * (6 + 4 * w)));
    end
    drive_px(gaps, w * h);
    n = 0;
    lim = 100 + 2 * w * h;
    while (bus.done_o !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done_o, 1'b1);
    chk("busy_at_done", bus.busy_o, 1'b1);
    chk("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("busy_idle", bus.busy_o, 1'b0);
    chk("done_pulse", bus.done_o, 1'b0);
    @(negedge clk);
    chk("lst_once", lst_total - l0, 1);
    chk("done_once", done_total - d0, 1);
    exp_q.delete();
  endtask
  // Scoreboard pop, lst/done ordering and row-gap width of pix_rdy_o.
  always @(negedge clk) begin
    if (!rstn) begin
      armed <= 1'b0;
      rdy_prev <= 1'b0;
      lst_prev <= 1'b0;
    end else begin
      rdy_prev <= bus.pix_rdy_o;
      if (rdy_prev && !bus.pix_rdy_o) begin
        armed <= 1'b1;
        low_run <= 1;
      end else if (!bus.pix_rdy_o && armed) low_run <= low_run + 1;
      else if (bus.pix_rdy_o && armed) begin
        chk("rdy_gap", low_run, 2);
        armed <= 1'b0;
      end
      if (bus.done_o) begin
        armed <= 1'b0;
        done_total <= done_total + 1;
      end
      lst_prev <= bus.val_o && bus.lst_o;
      if (bus.val_o && bus.lst_o) lst_total <= lst_total + 1;
      if (bus.done_o || lst_prev) chk("done_after_lst", bus.done_o, lst_prev);
      if (bus.val_o) begin
        chk("word_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("word_dat", bus.dat_o, exp_q[0].d);
          chk("word_lst", bus.lst_o, exp_q[0].l);
          if (exp_q[0].l) chk("lst_nb", bus.lst_nb_o, exp_q[0].n);
          void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    int l, d, t;
    bus.start_i = 1'b0;
    bus.w_i = '0;
    bus.h_i = '0;
    bus.pix_val_i = 1'b0;
    bus.pix_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_val", bus.val_o, 1'b0);
    chk("rst_dat", bus.dat_o, 32'h0);
    chk("rst_lst", bus.lst_o, 1'b0);
    chk("rst_nb", bus.lst_nb_o, 3'd0);
    chk("rst_len", bus.len_o, 32'h0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_rdy", bus.pix_rdy_o, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    px = {32'hFF0000FF};
    exp_q.push_back('{d: 32'h78010105, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'h00FAFF00, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'hFF0000FF, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'h050001FF, l: 1'b1, n: 3'd4});
    frame(1, 1, 0, 0, 0);
    chk("s1_len", bus.len_o, 32'd16);
    px = {32'hFF0000FF, 32'h00000000};
    frame(1, 2, 0, 0, 1);
    chk("s2_len", bus.len_o, 32'd26);
    px.delete();
    for (int i = 0; i < 12; i++) px.push_back($urandom);
    frame(3, 4, 1, 0, 1);
    l = bus.len_o;
    d = done_total;
    start(0, 1);
    chk("ill_w0_busy", bus.busy_o, 1'b0);
    chk("ill_w0_len", bus.len_o, l);
    start(1, 0);
    chk("ill_h0_busy", bus.busy_o, 1'b0);
    chk("ill_h0_len", bus.len_o, l);
    start(16384, 1);
    chk("ill_wmax_busy", bus.busy_o, 1'b0);
    chk("ill_wmax_len", bus.len_o, l);
    repeat (5) @(negedge clk);
    chk("ill_no_done", done_total, d);
    px.delete();
    for (int i = 0; i < 4; i++) px.push_back($urandom);
    frame(2, 2, 1, 1, 1);
    px.delete();
    for (int i = 0; i < 6; i++) px.push_back($urandom);
    model(2, 3);
    d = done_total;
    t = lst_total;
    start(2, 3);
    drive_px(0, 5);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_val", bus.val_o, 1'b0);
    chk("mid_rst_dat", bus.dat_o, 32'h0);
    chk("mid_rst_len", bus.len_o, 32'h0);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_rdy", bus.pix_rdy_o, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", done_total, d);
    chk("mid_rst_no_lst", lst_total, t);
    px = {32'hFF0000FF};
    exp_q.push_back('{d: 32'h78010105, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'h00FAFF00, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'hFF0000FF, l: 1'b0, n: 3'd0});
    exp_q.push_back('{d: 32'h050001FF, l: 1'b1, n: 3'd4});
    frame(1, 1, 0, 0, 0);
    px.delete();
    for (int i = 0; i < 4096 * 16; i++) px.push_back(32'hFFFFFFFF);
    frame(4096, 16, 0, 0, 1);
    chk("corner_len", bus.len_o, 32'd262246);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/png_idat_zlib.md
# png_idat_zlib

Generates the zlib-wrapped IDAT payload of the PNG encoder. It takes RGBA8 pixels in raster order, prefixes every row with filter type 0 (None), and wraps each row in its own deflate stored block. It appends the zlib header and an Adler-32 trailer and packs the byte stream into big-endian 32-bit words. Its output feeds the IDAT data input (val/dat/lst) of `crc32` and the chunk writer, and it reports the total payload length for the IDAT length field.

## Interface
- `W_MAX`, 16383, maximum supported width in pixels; keeps the stored-block LEN (1+4w) at or below 65535.
- `clk`  in  1  clock
- `rstn`  in  1  asynchronous, active-low reset
- `w_i`  in  32  image width in pixels; sampled on accepted `start_i`
- `h_i`  in  32  image height in rows; sampled on accepted `start_i`
- `start_i`  in  1  one-cycle pulse that begins a frame
- `pix_val_i`  in  1  pixel valid
- `pix_dat_i`  in  32  pixel {R[31:24], G, B, A[7:0]}
- `pix_rdy_o`  out  1  pixel accepted when `pix_val_i && pix_rdy_o`
- `val_o`  out  1  output word valid; no backpressure
- `dat_o`  out  32  stream bytes, first byte in [31:24]
- `lst_o`  out  1  marks the final word of the frame, qualified by `val_o`
- `lst_nb_o`  out  3  valid bytes in the `lst_o` word (1..4); pad bytes are 0x00
- `len_o`  out  32  payload byte count; valid from the cycle after accepted start until the next start
- `done_o`  out  1  one-cycle pulse, the cycle after the `lst_o` word
- `busy_o`  out  1  high from the cycle after accepted start until `done_o` inclusive

## Operation
- **Start acceptance.**
  - `start_i` is accepted only in IDLE with 1 ≤ `w_i` ≤ W_MAX and `h_i` ≥ 1.
  - Any other start is ignored: no outputs change and `done_o` does not fire.
  - `start_i` is ignored while busy.
- **Length.** `len_o` = 2 + `h_i`·(6 + 4·`w_i`) + 4, computed with 32-bit wrap.
- **Byte stream, in order:**
  - zlib header 0x78 0x01.
  - Per row r: BFINAL byte (0x01 if r = h−1, else 0x00), LEN[7:0], LEN[15:8], NLEN[7:0], NLEN[15:8], filter byte 0x00, then 4·w pixel bytes in R,G,B,A order. LEN = 1+4w and NLEN = ~LEN (16 bit), both little-endian.
  - Adler-32 trailer, big-endian: s2[15:8], s2[7:0], s1[15:8], s1[7:0].
- **Adler-32.**
  - Covers the filter bytes and pixel bytes only; the zlib header and block headers are excluded.
  - Initial values: s1 = 1, s2 = 0.
  - Filter byte update: s2 += s1.
  - Pixel update (bytes b0..b3): s1' = s1+b0+b1+b2+b3; s2' = s2 + 4·s1 + 4b0 + 3b1 + 2b2 + b3.
  - Both are fully reduced mod 65521 in the same cycle (chained conditional subtracts).
- **FSM states:** IDLE, ZHDR, BHD0, BHD1, PIX, ADLR, FLSH.
  - IDLE→ZHDR on accepted start.
  - ZHDR inserts 2 bytes →BHD0.
  - BHD0 inserts 4 bytes →BHD1.
  - BHD1 inserts NLEN[15:8] and the filter byte →PIX.
  - PIX inserts 4 bytes per accepted pixel. On the last pixel of a row it goes →BHD0, or →ADLR after the last row.
  - ADLR inserts 4 bytes →FLSH.
  - FLSH emits the residual partial word, if any, with `lst_o` →IDLE.
  - If the residual is empty, the ADLR word itself carries `lst_o` and FLSH only pulses `done_o`.
- **Packer.**
  - 7-byte accumulator; at most 4 bytes are inserted per cycle.
  - Whenever the accumulator holds ≥4 bytes, it emits one word and keeps the remainder (0..3 bytes). It cannot overflow.
- `pix_rdy_o` = 1 only in PIX.

## Timing
- Reset values: all outputs 0; FSM in IDLE; accumulator empty.
- Reset mid-frame discards all state immediately; no `lst_o` or `done_o` is produced.
- Cycle-level sequence:
  - ZHDR is entered the cycle after `start_i`.
  - A word is emitted (`val_o`) the cycle after the insertion that completes it.
  - `pix_rdy_o` drops for exactly 2 cycles (BHD0, BHD1) between rows.
  - Pixel throughput is 1 per cycle within a row.
  - The `pix_val_i` = 0 cycles stall the FSM in PIX and insert nothing.
- `val_o` is high at most one cycle in any cycle; consecutive cycles are allowed.
- `lst_o` asserts exactly once per frame. `done_o` follows in the next cycle, and IDLE is re-entered with it.

## Test plan
- **w=1, h=1, pixel 0xFF0000FF, no stalls.**
  - Output words 0x78010105, 0x00FAFF00, 0xFF0000FF, 0x050001FF.
  - `lst_o` on the 4th word, `lst_nb_o`=4, `len_o`=16, `done_o` one cycle later.
- **w=1, h=2, pixels 0xFF0000FF then 0x00000000.**
  - 26 bytes in 7 words.
  - First block header byte 0x00, second 0x01.
  - Last word has `lst_nb_o`=2 and pad 0x0000.
  - Adler matches the software zlib reference.
- **w=3, h=4, random pixels with random `pix_val_i` gaps.**
  - Output byte-identical to a software zlib stored-block model.
  - `pix_rdy_o` low exactly 2 cycles per row boundary.
- **Illegal starts** (`w_i`=0, `h_i`=0, `w_i`=16384, and start while busy): no state change, no `done_o`; an in-flight frame still completes correctly.
- **Reset mid-frame:** assert `rstn`=0 during PIX of row 2.
  - All outputs 0 and `pix_rdy_o`=0.
  - A following w=1, h=1 frame reproduces scenario 1 exactly.
- **Adler reduction corner, w=4096, h=16, all pixels 0xFFFFFFFF.**
  - Adler equals the software value, exercising the multi-subtract s2 reduction.
  - `len_o`=2+16·16390+4=262246.
